// File: rtl/float_mul_iter.sv
`timescale 1ns/1ps
// float_mul_iter: iterative (one bit per cycle) floating-point multiplier front end.
// Produces the unnormalised {sign, exp, man} triple plus a NaN flag for float_combine.
module float_mul_iter #(
    parameter  int EXP_WIDTH   = 8,
    parameter  int MAN_WIDTH   = 23,
    localparam int FLOAT_WIDTH = EXP_WIDTH + MAN_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLOAT_WIDTH-1:0] a,
    input  logic [FLOAT_WIDTH-1:0] b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   sign,
    output logic [EXP_WIDTH+1:0]   exp,
    output logic [MAN_WIDTH+2:0]   man,
    output logic                   is_nan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int SIG_W  = MAN_WIDTH + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int CNT_W  = $clog2(MAN_WIDTH + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAN_WIDTH);
    localparam logic [EXP_WIDTH+1:0] BIAS     = (EXP_WIDTH + 2)'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SIG_W-1:0]     r_mcand;
    logic [PROD_W-1:0]    r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_sign;
    logic [EXP_WIDTH+1:0] r_exp;
    logic [MAN_WIDTH+2:0] r_man;
    logic                 r_is_nan;
    logic                 r_out_valid;

    // Operand field decode
    logic [EXP_WIDTH-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff;
    logic [MAN_WIDTH-1:0] w_ma, w_mb;
    logic                 w_a_zexp, w_b_zexp, w_a_max, w_b_max;
    logic                 w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic                 w_special, w_res_nan, w_res_inf, w_accept, w_last;
    logic [EXP_WIDTH+1:0] w_exp_sum;
    logic [SIG_W:0]       w_addend, w_sum;
    logic [PROD_W-1:0]    w_next_acc;

    assign w_ea     = a[FLOAT_WIDTH-2 -: EXP_WIDTH];
    assign w_eb     = b[FLOAT_WIDTH-2 -: EXP_WIDTH];
    assign w_ma     = a[MAN_WIDTH-1:0];
    assign w_mb     = b[MAN_WIDTH-1:0];
    assign w_a_zexp = (w_ea == '0);
    assign w_b_zexp = (w_eb == '0);
    assign w_a_max  = (w_ea == EXP_ONES);
    assign w_b_max  = (w_eb == EXP_ONES);
    assign w_a_nan  = w_a_max && (w_ma != '0);
    assign w_b_nan  = w_b_max && (w_mb != '0);
    assign w_a_inf  = w_a_max && (w_ma == '0);
    assign w_b_inf  = w_b_max && (w_mb == '0);
    assign w_a_zero = w_a_zexp && (w_ma == '0);
    assign w_b_zero = w_b_zexp && (w_mb == '0);

    // Subnormals use an effective exponent of 1 with a zero hidden bit.
    assign w_ea_eff  = w_a_zexp ? EXP_WIDTH'(1) : w_ea;
    assign w_eb_eff  = w_b_zexp ? EXP_WIDTH'(1) : w_eb;
    assign w_exp_sum = {2'b00, w_ea_eff} + {2'b00, w_eb_eff} - BIAS;

    assign w_res_nan = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
    assign w_res_inf = w_a_inf || w_b_inf;
    assign w_special = w_a_nan || w_b_nan || w_a_inf || w_b_inf || w_a_zero || w_b_zero;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CNT_LAST);

    // Shift-add step: the multiplier sits in the low half of the accumulator and
    // is consumed LSB first while partial sums shift in from the top.
    assign w_addend   = r_acc[0] ? {1'b0, r_mcand} : '0;
    assign w_sum      = {1'b0, r_acc[PROD_W-1:SIG_W]} + w_addend;
    assign w_next_acc = {w_sum, r_acc[SIG_W-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode
    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_special ? S_DONE : S_MUL;
            S_MUL:  if (w_last)   w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, special resolution, shift-add loop, result hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_man       <= '0;
            r_is_nan    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign      <= a[FLOAT_WIDTH-1] ^ b[FLOAT_WIDTH-1];
                        r_is_nan    <= w_res_nan;
                        r_out_valid <= w_special;
                        r_mcand     <= {~w_a_zexp, w_ma};
                        r_acc       <= {{SIG_W{1'b0}}, ~w_b_zexp, w_mb};
                        r_cnt       <= '0;
                        if (w_res_nan) begin
                            r_exp <= '0;
                            r_man <= '0;
                        end else if (w_res_inf) begin
                            r_exp <= {2'b00, EXP_ONES};
                            r_man <= (MAN_WIDTH + 3)'(1) << MAN_WIDTH;
                        end else if (w_special) begin
                            r_exp <= '0;
                            r_man <= '0;
                        end else begin
                            r_exp <= w_exp_sum;
                            r_man <= '0;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_next_acc;
                    if (w_last) begin
                        r_man       <= {1'b0, w_next_acc[PROD_W-1:MAN_WIDTH]};
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign sign      = r_sign;
    assign exp       = r_exp;
    assign man       = r_man;
    assign is_nan    = r_is_nan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_float_mul_iter.sv
`timescale 1ns/1ps
// Self-checking bench for float_mul_iter: reference model from plain integer
// arithmetic, a per-cycle compare process, directed and randomized operations.
module tb_float_mul_iter;

    localparam int EW = 8;
    localparam int MW = 23;
    localparam int FW = EW + MW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] a = '0, b = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sign;
    logic [EW+1:0] exp;
    logic [MW+2:0] man;
    logic          is_nan;
    logic          out_valid;
    logic          out_ready = 1'b0;

    float_mul_iter #(.EXP_WIDTH(EW), .MAN_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .exp(exp), .man(man), .is_nan(is_nan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sign;
        logic [EW+1:0] e;
        logic [MW+2:0] m;
        logic          nan;
        int            lat;   // cycle index (1-based after accept) of first out_valid
        int            base;  // absolute cycle number of cycle 1
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   seen   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: IEEE-style classification and an exact integer product.
    function automatic exp_t model(input logic [FW-1:0] x, input logic [FW-1:0] y);
        exp_t r;
        int unsigned ex, ey, mx, my;
        bit nx, ny, ix, iy, zx, zy;
        longint unsigned sx, sy, prod;
        int e_int;
        ex = int'(x[FW-2 -: EW]); ey = int'(y[FW-2 -: EW]);
        mx = int'(x[MW-1:0]);     my = int'(y[MW-1:0]);
        nx = (ex == 255) && (mx != 0); ny = (ey == 255) && (my != 0);
        ix = (ex == 255) && (mx == 0); iy = (ey == 255) && (my == 0);
        zx = (ex == 0) && (mx == 0);   zy = (ey == 0) && (my == 0);
        r.sign = x[FW-1] ^ y[FW-1];
        r.lat  = 1;
        r.base = 0;
        r.nan  = 1'b0;
        r.e    = '0;
        r.m    = '0;
        if (nx || ny || (ix && zy) || (iy && zx)) begin
            r.nan = 1'b1;
        end else if (ix || iy) begin
            r.e = 10'd255;
            r.m = (MW + 3)'(1 << MW);
        end else if (zx || zy) begin
            // zero result already set
        end else begin
            sx    = (ex == 0) ? longint'(mx) : longint'(mx) + (64'd1 << MW);
            sy    = (ey == 0) ? longint'(my) : longint'(my) + (64'd1 << MW);
            prod  = sx * sy;
            r.m   = (MW + 3)'(prod >> MW);
            e_int = ((ex == 0) ? 1 : int'(ex)) + ((ey == 0) ? 1 : int'(ey)) - 127;
            r.e   = (EW + 2)'(e_int);
            r.lat = MW + 2;
        end
        return r;
    endfunction

    // Compare process: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                cur = exp_q[0];
                check("sign",     64'(sign),     64'(cur.sign));
                check("exp",      64'(exp),      64'(cur.e));
                check("man",      64'(man),      64'(cur.m));
                check("is_nan",   64'(is_nan),   64'(cur.nan));
                check("in_ready_busy", 64'(in_ready), 64'd0);
                if (!seen) begin
                    check("latency", 64'(cyc - cur.base + 1), 64'(cur.lat));
                    seen = 1'b1;
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Issue one operation and complete its output handshake after `hold` stalled cycles.
    task automatic run_op(input logic [FW-1:0] op_a, input logic [FW-1:0] op_b, input int hold);
        exp_t e;
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        check("in_ready_before_issue", 64'(in_ready), 64'd1);
        a = op_a; b = op_b; in_valid = 1'b1; out_ready = 1'b0;
        e = model(op_a, op_b);
        @(posedge clk); #1;
        e.base = cyc;
        exp_q.push_back(e);
        // Garbage on the inputs while busy must not disturb the result.
        a = $urandom; b = $urandom; in_valid = 1'($urandom_range(0, 1));
        guard = 0;
        while (!out_valid && guard < 60) begin @(posedge clk); #1; guard++; end
        in_valid = 1'b0;
        if (!out_valid) begin
            check("out_valid_timeout", 64'(out_valid), 64'd1);
            exp_q.delete();
            seen = 1'b0;
        end
        repeat (hold) begin
            @(posedge clk); #1;
            check("in_ready_stall", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs",  64'(in_ready),  64'd1);
    endtask

    function automatic logic [FW-1:0] rand_operand();
        logic [FW-1:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: v[FW-2:0] = '0;                                   // zero
            1: begin v[FW-2 -: EW] = '1; v[MW-1:0] = '0; end      // infinity
            2: begin v[FW-2 -: EW] = '1; v[MW-1] = 1'b1; end      // NaN
            3: begin v[FW-2 -: EW] = '0; v[0] = 1'b1; end         // subnormal
            default: v[FW-2 -: EW] = EW'($urandom_range(1, 254));  // normal
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t m;

        // Pin the model with hand-computed values.
        m = model(32'h3FC00000, 32'h40000000);
        check("model_basic_exp", 64'(m.e), 64'h080);
        check("model_basic_man", 64'(m.m), 64'h0C00000);
        m = model(32'hBFC00000, 32'h3FC00000);
        check("model_carry_man", 64'(m.m), 64'h1200000);
        check("model_carry_sign", 64'(m.sign), 64'd1);
        m = model(32'h7F800000, 32'hC0000000);
        check("model_inf_exp", 64'(m.e), 64'h0FF);
        m = model(32'h00800000, 32'h00800000);
        check("model_under_exp", 64'(m.e), 64'h383);
        m = model(32'h7F800000, 32'h00000000);
        check("model_infzero_nan", 64'(m.nan), 64'd1);

        // Reset values
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sign",      64'(sign),      64'd0);
        check("rst_exp",       64'(exp),       64'd0);
        check("rst_man",       64'(man),       64'd0);
        check("rst_is_nan",    64'(is_nan),    64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed operations
        run_op(32'h3FC00000, 32'h40000000, 0);   // basic product
        run_op(32'hBFC00000, 32'h3FC00000, 0);   // carry into headroom
        run_op(32'h7FC00000, 32'h3F800000, 0);   // NaN operand
        run_op(32'h7F800000, 32'h00000000, 0);   // inf x zero
        run_op(32'h7F800000, 32'hC0000000, 0);   // inf x nonzero
        run_op(32'h00000000, 32'h40400000, 0);   // zero x 3.0
        run_op(32'h00800000, 32'h00800000, 0);   // exponent underflow
        run_op(32'h3FC00000, 32'h40000000, 5);   // backpressure

        // Reset in MUL at cycle 10
        a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_man",       64'(man),       64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            check("abort_no_result", 64'(out_valid), 64'd0);
        end
        run_op(32'h3FC00000, 32'h40000000, 0);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            run_op(rand_operand(), rand_operand(), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
